top_cnn_image_processor: RTL and testbench
==========================================

TOP_CNN_IMAGE_PROCESSOR -- requirements
Module: top_cnn_image_processor

Interface
REQ-001 SHALL have parameter IMG_W, default 128: pixels per image row.
REQ-002 SHALL have parameter IMG_H, default 128: rows per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port S  input  1  pixel-valid/start; X, Y, Z are sampled only on edges where S=1.
REQ-006 SHALL have port X  input  8  unsigned red pixel.
REQ-007 SHALL have port Y  input  8  unsigned green pixel.
REQ-008 SHALL have port Z  input  8  unsigned blue pixel.
REQ-009 SHALL have port E  output  13  signed edge result, registered.
REQ-010 SHALL have port Save  output  1  registered strobe; high exactly on cycles where E is a valid result.

Function
REQ-011 SHALL accept pixels in raster order (row 0 col 0 first), one per cycle with S=1; an internal column counter (0..IMG_W-1) and row counter (0..IMG_H-1) advance only on accepted pixels.
REQ-012 SHALL wrap: after pixel (IMG_H-1, IMG_W-1), the next accepted pixel is (0,0) of a new frame.
REQ-013 SHALL hold two line buffers of IMG_W x 8 bits per channel plus a 3x3 window per channel.
REQ-014 SHALL apply Sobel Gx = [-1 0 +1; -2 0 +2; -1 0 +1] (left column negative) to each channel's 3x3 window, using shifts/adds only, no multipliers.
REQ-015 SHALL sum the three channel results into a signed value in the range -3060..+3060, computed at 13 bits without overflow.
REQ-016 SHALL produce a result only for fully populated windows: accepted pixel (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1), giving (IMG_H-2)x(IMG_W-2) = 126x126 = 15876 results per frame.
REQ-017 SHALL use a 5-stage pipeline:
  - 1: input register + window shift
  - 2: coefficient terms
  - 3: per-column sums
  - 4: per-channel Gx
  - 5: cross-channel sum to E
REQ-018 SHALL drive E and Save on the 5th rising edge after the completing pixel is sampled (latency 5 cycles).
REQ-019 SHALL advance the pipeline every cycle with a per-stage valid bit; S=0 cycles insert bubbles and produce no Save pulse.
REQ-020 SHALL set E=0 whenever Save=0.
REQ-021 SHALL never assert Save for windows straddling a row wrap (c<2) or a frame wrap (r<2).

Reset
REQ-022 SHALL, while reset=1 at a clock edge, clear the row/column counters, all pipeline valid bits, E to 0 and Save to 0; line-buffer contents need not be cleared.
REQ-023 SHALL, on reset mid-frame, discard all in-flight results (no Save after reset until new valid windows) and treat the first accepted pixel after reset as (0,0).
REQ-024 SHALL give reset priority over S on the same edge.

Configuration
REQ-025 SHALL, when macro CLAMP_OUT_EN is defined, make E the stage-5 sum clamped to 0..255 (negative values give 0, >255 gives 255, zero-extended to 13 bits).
REQ-026 SHALL, when CLAMP_OUT_EN is not defined, make E the raw signed sum; latency SHALL be 5 in both builds.

Verification
REQ-027 Constant frame X=Y=Z=100, S=1 continuously -> exactly 15876 Save pulses per frame, 126 per row, all with E=0.
REQ-028 Horizontal ramp X=c, Y=Z=0 (raw build) -> every valid E = +8; first Save exactly 5 cycles after pixel (2,2) is sampled, i.e. accepted-pixel index 258.
REQ-029 Vertical step, all channels 0 for c<64 and 255 for c>=64 -> E=3060 at centre columns 63 and 64, E=0 elsewhere; with CLAMP_OUT_EN, 255 at those columns; reversed step gives -3060 raw and 0 clamped.
REQ-030 S toggled 1/0 every cycle on a ramp frame -> identical E sequence to REQ-028, Save pulses spaced by the gaps, total 15876.
REQ-031 reset asserted for one cycle mid-row 50, then a fresh frame streamed -> no Save within the 5 cycles after reset; next frame yields the full 15876 correct results.
REQ-032 Two back-to-back frames with no idle gap -> no Save for the first two rows and columns of frame 2; the frame-2 result count equals 15876.

Source files
------------

// File: rtl/top_cnn_image_processor.sv
// Streaming Sobel-Gx edge detector over RGB pixels in raster order.
// Two line buffers plus a 3x3 window per channel feed a shift/add
// pipeline; the three channel gradients are summed into a 13-bit E.
// Build option: define CLAMP_OUT_EN to clamp E to 0..255 instead of
// emitting the raw signed sum. Latency is 5 cycles in both builds.
//
// Handshake: S=1 marks X/Y/Z as a valid pixel on that edge (no
// backpressure). Save=1 marks E as a valid result on that cycle; E
// reads 0 whenever Save=0.
module top_cnn_image_processor #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               S,
  input  logic [7:0]         X,
  input  logic [7:0]         Y,
  input  logic [7:0]         Z,
  output logic signed [12:0] E,
  output logic               Save
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Raster position of the next accepted pixel
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_ok;

  // Stage 1a: registered pixel and its position
  logic          in_vld_q, in_win_q;
  logic [CW-1:0] in_col_q;
  logic [7:0]    in_px_q [3];

  // Stage 1b: line buffers (row r-1 in lb0, row r-2 in lb1) and window
  logic [7:0]    lb0_q [3][IMG_W];
  logic [7:0]    lb1_q [3][IMG_W];
  logic [7:0]    win_q [3][3][3];   // [channel][row][col], col 2 newest
  logic          v1_q;

  // Stages 2..5
  logic [8:0]         lt_q [3][3];  // left-column weighted terms
  logic [8:0]         rt_q [3][3];  // right-column weighted terms
  logic               v2_q;
  logic [9:0]         ls_q [3];
  logic [9:0]         rs_q [3];
  logic               v3_q;
  logic signed [10:0] gx_q [3];
  logic               v4_q;
  logic signed [12:0] sum_d, e_d, e_q;
  logic               save_q;

  // Next raster position: column wraps into the row, row wraps into the frame
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (S) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // A pixel at (r,c) completes a full window only when r>=2 and c>=2
  assign win_ok = (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Position counters; reset wins over S
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Valid bits and output register: all cleared by reset to drop in-flight work
  always_ff @(posedge clk) begin
    if (reset) begin
      in_vld_q <= 1'b0;
      in_win_q <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      v4_q     <= 1'b0;
      save_q   <= 1'b0;
      e_q      <= '0;
    end else begin
      in_vld_q <= S;
      in_win_q <= S && win_ok;
      v1_q     <= in_vld_q && in_win_q;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      v4_q     <= v3_q;
      save_q   <= v4_q;
      e_q      <= v4_q ? e_d : '0;
    end
  end

  // Input register: capture pixel and column for the window stage
  always_ff @(posedge clk) begin
    in_col_q   <= col_q;
    in_px_q[0] <= X;
    in_px_q[1] <= Y;
    in_px_q[2] <= Z;
  end

  // Window shift and line-buffer update, only for accepted pixels
  always_ff @(posedge clk) begin
    if (in_vld_q) begin
      for (int ch = 0; ch < 3; ch++) begin
        lb1_q[ch][in_col_q] <= lb0_q[ch][in_col_q];
        lb0_q[ch][in_col_q] <= in_px_q[ch];
        for (int r = 0; r < 3; r++) begin
          win_q[ch][r][0] <= win_q[ch][r][1];
          win_q[ch][r][1] <= win_q[ch][r][2];
        end
        win_q[ch][0][2] <= lb1_q[ch][in_col_q];
        win_q[ch][1][2] <= lb0_q[ch][in_col_q];
        win_q[ch][2][2] <= in_px_q[ch];
      end
    end
  end

  // Datapath stages: weighted terms, column sums, per-channel gradient
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 3; ch++) begin
      for (int r = 0; r < 3; r++) begin
        lt_q[ch][r] <= (r == 1) ? {win_q[ch][r][0], 1'b0} : {1'b0, win_q[ch][r][0]};
        rt_q[ch][r] <= (r == 1) ? {win_q[ch][r][2], 1'b0} : {1'b0, win_q[ch][r][2]};
      end
      ls_q[ch] <= {1'b0, lt_q[ch][0]} + {1'b0, lt_q[ch][1]} + {1'b0, lt_q[ch][2]};
      rs_q[ch] <= {1'b0, rt_q[ch][0]} + {1'b0, rt_q[ch][1]} + {1'b0, rt_q[ch][2]};
      gx_q[ch] <= $signed({1'b0, rs_q[ch]}) - $signed({1'b0, ls_q[ch]});
    end
  end

  // Cross-channel sum, sign-extended to 13 bits, optionally clamped
  always_comb begin
    sum_d = {{2{gx_q[0][10]}}, gx_q[0]}
          + {{2{gx_q[1][10]}}, gx_q[1]}
          + {{2{gx_q[2][10]}}, gx_q[2]};
`ifdef CLAMP_OUT_EN
    if (sum_d[12]) begin
      e_d = '0;
    end else if (sum_d > 13'sd255) begin
      e_d = 13'sd255;
    end else begin
      e_d = sum_d;
    end
`else
    e_d = sum_d;
`endif
  end

  assign E    = e_q;
  assign Save = save_q;

endmodule

// File: tb/tb_top_cnn_image_processor.sv
// Scoreboard bench for top_cnn_image_processor: a frame-image reference
// model queues expected results; a negedge monitor pops and compares.
module tb_top_cnn_image_processor;

  localparam int W    = 32;
  localparam int H    = 12;
  localparam int NRES = (W - 2) * (H - 2);
  localparam int QW   = 45;   // {accept edge[31:0], expected E[12:0]}

  // ---------------- clock / reset ----------------
  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic               S     = 1'b0;
  logic [7:0]         X     = '0;
  logic [7:0]         Y     = '0;
  logic [7:0]         Z     = '0;
  logic signed [12:0] E;
  logic               Save;

  top_cnn_image_processor #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .reset (reset),
    .S     (S),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .E     (E),
    .Save  (Save)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int             chk_cnt  = 0;
  int             pass_cnt = 0;
  int             save_cnt = 0;
  bit             mon_en   = 1'b0;
  logic [QW-1:0]  exp_q[$];
  logic [QW-1:0]  ent;
  int             img[3][H][W];
  int             mr = 0;
  int             mc = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Pixel patterns: 0 random, 1 constant 100, 2 red ramp, 3 step up, 4 step down
  function automatic int pix(input int kind, input int ch, input int c);
    case (kind)
      0:       return int'($urandom_range(0, 255));
      1:       return 100;
      2:       return (ch == 0) ? c : 0;
      3:       return (c >= W / 2) ? 255 : 0;
      4:       return (c >= W / 2) ? 0 : 255;
      default: return 0;
    endcase
  endfunction

  // Sobel Gx summed over channels for the window whose bottom-right is (r,c)
  function automatic int ref_e(input int r, input int c);
    int g = 0;
    for (int ch = 0; ch < 3; ch++)
      for (int dr = 0; dr < 3; dr++)
        g += ((dr == 1) ? 2 : 1) * (img[ch][r - 2 + dr][c] - img[ch][r - 2 + dr][c - 2]);
`ifdef CLAMP_OUT_EN
    if (g < 0) g = 0;
    else if (g > 255) g = 255;
`endif
    return g;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_px(input int kind);
    int p[3];
    int e;
    for (int ch = 0; ch < 3; ch++) p[ch] = pix(kind, ch, mc);
    @(posedge clk); #1;
    S = 1'b1;
    X = 8'(p[0]);
    Y = 8'(p[1]);
    Z = 8'(p[2]);
    for (int ch = 0; ch < 3; ch++) img[ch][mr][mc] = p[ch];
    if (mr >= 2 && mc >= 2) begin
      e = ref_e(mr, mc);
      exp_q.push_back({32'(cyc + 1), 13'(e)});
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    S = 1'b0;
    X = 8'($urandom_range(0, 255));
    Y = 8'($urandom_range(0, 255));
    Z = 8'($urandom_range(0, 255));
  endtask

  // smode: 0 back-to-back, 1 one idle after each pixel, 2 random 0..2 idles
  task automatic send(input int kind, input int smode, input int n);
    for (int i = 0; i < n; i++) begin
      drive_px(kind);
      if (smode == 1) idle();
      else if (smode == 2) repeat ($urandom_range(0, 2)) idle();
    end
    idle();
  endtask

  task automatic settle(input int n);
    repeat (n) idle();
  endtask

  // One-cycle reset with S=1 on the same edge; results not yet on E are dropped
  task automatic do_reset();
    logic [QW-1:0] last;
    @(posedge clk); #1;
    reset = 1'b1;
    S = 1'b1;
    X = 8'($urandom_range(0, 255));
    Y = 8'($urandom_range(0, 255));
    Z = 8'($urandom_range(0, 255));
    while (exp_q.size() > 0) begin
      last = exp_q[exp_q.size() - 1];
      if (int'(last[QW-1:13]) + 5 > cyc) void'(exp_q.pop_back());
      else break;
    end
    mr = 0;
    mc = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    S = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (Save) begin
        save_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_save: Save=1 E=%0d at cycle %0d, expected no result", E, cyc);
        end else begin
          ent = exp_q.pop_front();
          check("e_value", int'(E), int'($signed(ent[12:0])));
          check("latency", cyc, int'(ent[QW-1:13]) + 5);
        end
      end else begin
        check("e_idle", int'(E), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_save", int'(Save), 0);
    check("reset_e", int'(E), 0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    save_cnt = 0; send(1, 0, W * H); settle(8);
    check("count_const", save_cnt, NRES);

    save_cnt = 0; send(2, 0, W * H); settle(8);
    check("count_ramp", save_cnt, NRES);

    save_cnt = 0; send(3, 0, W * H); settle(8);
    check("count_step", save_cnt, NRES);

    save_cnt = 0; send(4, 0, W * H); settle(8);
    check("count_rstep", save_cnt, NRES);

    save_cnt = 0; send(2, 1, W * H); settle(8);
    check("count_toggle", save_cnt, NRES);

    save_cnt = 0; send(0, 2, W * H); settle(8);
    check("count_rand_gaps", save_cnt, NRES);

    send(2, 0, 7 * W + W / 2);
    do_reset();
    save_cnt = 0; settle(6);
    check("no_save_after_reset", save_cnt, 0);
    save_cnt = 0; send(0, 0, W * H); settle(8);
    check("count_after_reset", save_cnt, NRES);

    save_cnt = 0; send(0, 0, 2 * W * H); settle(8);
    check("count_back_to_back", save_cnt, 2 * NRES);

    check("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
